// File: rtl/pc_fetch_if.sv
// Fetch-unit signal bundle: run/stall/redirect control, ROM address/data and decoder-facing outputs.
// master = fetch unit, slave = surrounding core (decoder, execute, ROM).
interface pc_fetch_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned IW = 16,
    parameter int unsigned CW = 16
);
    logic          run;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_instr;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic [CW-1:0] fetch_count;

    modport master (
        input  run, stall, redirect_valid, redirect_target, rom_instr,
        output rom_addr, instr_out, instr_pc, instr_valid, fetch_count
    );

    modport slave (
        output run, stall, redirect_valid, redirect_target, rom_instr,
        input  rom_addr, instr_out, instr_pc, instr_valid, fetch_count
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end for a 1-cycle registered-read program ROM.
// Pairs each returned word with its address; supports hold, redirect and squash.
module pc_fetch #(
    parameter int unsigned AW       = 10,
    parameter int unsigned IW       = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_if.master    bus
);
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_f_pc;
    logic          r_f_valid;
    logic [CW-1:0] r_cnt;

    logic          w_hold;
    logic          w_accept;

    assign w_hold   = bus.stall | ~bus.run;
    // A word is consumed only when it is valid, not squashed, and not held.
    assign w_accept = r_f_valid & ~bus.redirect_valid & ~w_hold;

    // Holding replays the in-flight address so the ROM re-presents the same word.
    always_comb begin
        bus.rom_addr = r_pc;
        if (bus.redirect_valid) begin
            bus.rom_addr = bus.redirect_target;
        end else if (w_hold) begin
            bus.rom_addr = r_f_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= AW'(RESET_PC);
            r_f_pc    <= AW'(RESET_PC);
            r_f_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_f_pc    <= bus.redirect_target;
            r_f_valid <= 1'b1;
            r_pc      <= bus.redirect_target + AW'(1);
        end else if (!w_hold) begin
            r_f_pc    <= r_pc;
            r_f_valid <= 1'b1;
            r_pc      <= r_pc + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bus.instr_out   = bus.rom_instr;
    assign bus.instr_pc    = r_f_pc;
    assign bus.instr_valid = r_f_valid & ~bus.redirect_valid;
    assign bus.fetch_count = r_cnt;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, stall/run hold, loop redirects,
// redirect vs stall, address wrap, async reset, and counter saturation (narrow instance).
module tb_pc_fetch;
    logic clk;
    logic rst_n;
    logic rst_n_s;

    int checks = 0;
    int errors = 0;

    pc_fetch_if #(.AW(10), .IW(16), .CW(16)) bus ();
    pc_fetch_if #(.AW(10), .IW(16), .CW(3))  bus_s ();

    pc_fetch #(.AW(10), .IW(16), .RESET_PC(0), .CW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    pc_fetch #(.AW(10), .IW(16), .RESET_PC(0), .CW(3)) u_sat (
        .clk   (clk),
        .rst_n (rst_n_s),
        .bus   (bus_s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [9:0] a);
        return {6'b101101, a};
    endfunction

    // Registered-read ROM, one cycle latency.
    always @(posedge clk) bus.rom_instr <= word(bus.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic v, input logic [9:0] pc,
                      input logic [9:0] ra, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(v));
        chk({tag, ".pc"},    32'(bus.instr_pc),    32'(pc));
        chk({tag, ".addr"},  32'(bus.rom_addr),    32'(ra));
        chk({tag, ".cnt"},   32'(bus.fetch_count), 32'(cnt));
        if (v) chk({tag, ".instr"}, 32'(bus.instr_out), 32'(word(pc)));
    endtask

    task automatic squash(input string tag, input logic [9:0] ra, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, ".addr"},  32'(bus.rom_addr),    32'(ra));
        chk({tag, ".cnt"},   32'(bus.fetch_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        rst_n_s = 1'b0;
        bus.run = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus_s.run = 1'b1;
        bus_s.stall = 1'b0;
        bus_s.redirect_valid = 1'b0;
        bus_s.redirect_target = '0;
        bus_s.rom_instr = '0;

        repeat (2) tick();
        st("reset", 1'b0, 10'd0, 10'd0, 16'd0);

        // Sequential fetch
        rst_n = 1'b1;
        #1;
        st("rel", 1'b0, 10'd0, 10'd0, 16'd0);
        tick(); st("f0", 1'b1, 10'd0, 10'd1, 16'd0);
        tick(); st("f1", 1'b1, 10'd1, 10'd2, 16'd1);
        tick(); st("f2", 1'b1, 10'd2, 10'd3, 16'd2);

        // Stall replays pc 2 for three cycles
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            st("stall", 1'b1, 10'd2, 10'd2, 16'd2);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        st("unstall", 1'b1, 10'd2, 10'd3, 16'd2);
        tick(); st("f3", 1'b1, 10'd3, 10'd4, 16'd3);
        tick(); st("f4", 1'b1, 10'd4, 10'd5, 16'd4);
        tick(); st("f5", 1'b1, 10'd5, 10'd6, 16'd5);

        // Loop 5 -> 3, four times; squashed pc 5 never counted
        for (int k = 0; k < 4; k++) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_target = 10'd3;
            #1;
            squash("jmp", 10'd3, 16'(5 + 2 * k));
            tick();
            bus.redirect_valid = 1'b0;
            #1;
            st("j3", 1'b1, 10'd3, 10'd4, 16'(5 + 2 * k));
            tick(); st("j4", 1'b1, 10'd4, 10'd5, 16'(6 + 2 * k));
            tick(); st("j5", 1'b1, 10'd5, 10'd6, 16'(7 + 2 * k));
        end

        // Redirect wins over stall
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 10'h010;
        bus.stall = 1'b1;
        #1;
        squash("rs", 10'h010, 16'd13);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        st("rs_tgt", 1'b1, 10'h010, 10'h010, 16'd13);
        tick(); st("rs_hold", 1'b1, 10'h010, 10'h010, 16'd13);
        bus.stall = 1'b0;
        #1;
        st("rs_rel", 1'b1, 10'h010, 10'h011, 16'd13);
        tick(); st("f11", 1'b1, 10'h011, 10'h012, 16'd14);

        // Address wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 10'h3FE;
        #1;
        squash("wrap_j", 10'h3FE, 16'd14);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        st("w3fe", 1'b1, 10'h3FE, 10'h3FF, 16'd14);
        tick(); st("w3ff", 1'b1, 10'h3FF, 10'h000, 16'd15);
        tick(); st("w000", 1'b1, 10'h000, 10'h001, 16'd16);
        tick(); st("w001", 1'b1, 10'h001, 10'h002, 16'd17);

        // run=0 behaves like stall
        bus.run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            st("norun", 1'b1, 10'h001, 10'h001, 16'd17);
            tick();
        end
        bus.run = 1'b1;
        #1;
        st("run_rel", 1'b1, 10'h001, 10'h002, 16'd17);
        tick(); st("r2", 1'b1, 10'h002, 10'h003, 16'd18);

        // Async reset mid-stream at pc 0x2A
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 10'h02A;
        #1;
        squash("j2a", 10'h02A, 16'd18);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        st("p2a", 1'b1, 10'h02A, 10'h02B, 16'd18);
        #2;
        rst_n = 1'b0;
        #1;
        st("arst", 1'b0, 10'd0, 10'd0, 16'd0);
        tick(); st("arst_hold", 1'b0, 10'd0, 10'd0, 16'd0);
        rst_n = 1'b1;
        #1;
        st("rel2", 1'b0, 10'd0, 10'd0, 16'd0);
        tick(); st("g0", 1'b1, 10'd0, 10'd1, 16'd0);
        tick(); st("g1", 1'b1, 10'd1, 10'd2, 16'd1);

        // Counter saturation on the CW=3 instance
        rst_n_s = 1'b1;
        repeat (7) tick();
        chk("sat6", 32'(bus_s.fetch_count), 32'd6);
        tick();
        chk("sat7", 32'(bus_s.fetch_count), 32'd7);
        repeat (3) tick();
        chk("sat_hold", 32'(bus_s.fetch_count), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
